// File: rtl/layer_out_serializer_pkg.sv
// Shared layer-level definitions: FSM state encoding and a constant clog2.
// Imported by the serializer and other layer blocks.
package layer_out_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/layer_out_serializer.sv
// Captures all neuron outputs of one layer at once and streams them
// out one word per valid/ready transfer, neuron 0 first.
// Ports: clk, rst (sync, active-high), in_valid/in_data (parallel layer
// outputs), out_data/out_valid/out_ready/out_last (serial stream),
// busy (streaming), overflow_err/skew_err (sticky until rst).
module layer_out_serializer
    import layer_out_serializer_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS-1:0]            in_valid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              busy,
    output logic                              overflow_err,
    output logic                              skew_err
);

    localparam int CNT_WIDTH = clog2(NUM_NEURONS);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX =
        CNT_WIDTH'(NUM_NEURONS - 1);

    state_t                          state;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] hold;
    logic [CNT_WIDTH-1:0]            cnt;

    logic capture;
    logic partial;
    logic transfer;
    logic final_xfer;

    assign capture    = &in_valid;
    assign partial    = (|in_valid) & ~capture;
    assign transfer   = out_valid & out_ready;
    assign final_xfer = transfer & out_last;

    // All outputs derive from flops only; hold is zero whenever idle.
    assign out_data = hold[DATA_WIDTH-1:0];
    assign busy     = (state == ST_SHIFT);
    assign out_last = out_valid & (cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            hold         <= '0;
            cnt          <= '0;
            out_valid    <= 1'b0;
            overflow_err <= 1'b0;
            skew_err     <= 1'b0;
        end else begin
            if (partial) skew_err <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (capture) begin
                        hold      <= in_data;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (final_xfer && capture) begin
                        // Back-to-back set: no bubble between streams.
                        hold <= in_data;
                        cnt  <= '0;
                    end else if (final_xfer) begin
                        hold      <= '0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        if (capture) overflow_err <= 1'b1;
                        if (transfer) begin
                            hold <= hold >> DATA_WIDTH;
                            cnt  <= cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed scoreboard bench for layer_out_serializer (4 and 30 neurons).
// Expected words are queued at capture and checked on each transfer.
module tb_layer_out_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        overflow_err;
    logic        skew_err;

    logic [29:0]  in_valid30;
    logic [479:0] in_data30;
    logic [15:0]  out_data30;
    logic         out_valid30;
    logic         out_ready30;
    logic         out_last30;
    logic         busy30;
    logic         overflow_err30;
    logic         skew_err30;

    int checks = 0;
    int errors = 0;
    logic [16:0] q4[$];
    logic [16:0] q30[$];

    always #5 clk = ~clk;

    layer_out_serializer #(.NUM_NEURONS(4), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .overflow_err(overflow_err),
        .skew_err(skew_err)
    );

    layer_out_serializer #(.NUM_NEURONS(30), .DATA_WIDTH(16)) dut30 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid30), .in_data(in_data30),
        .out_data(out_data30), .out_valid(out_valid30),
        .out_ready(out_ready30), .out_last(out_last30),
        .busy(busy30), .overflow_err(overflow_err30),
        .skew_err(skew_err30)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                chk("n4_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                logic [16:0] e;
                e = q4.pop_front();
                chk("n4_data", 32'(out_data), 32'(e[15:0]));
                chk("n4_last", 32'(out_last), 32'(e[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid30 && out_ready30) begin
            if (q30.size() == 0) begin
                chk("n30_unexpected_word", 32'(out_data30), 32'hFFFF_FFFF);
            end else begin
                logic [16:0] e;
                e = q30.pop_front();
                chk("n30_data", 32'(out_data30), 32'(e[15:0]));
                chk("n30_last", 32'(out_last30), 32'(e[16]));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_set(input logic [15:0] first, input bit push);
        in_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_data[i*16 +: 16] = first + 16'(i);
            if (push) q4.push_back({(i == 3), first + 16'(i)});
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b1;
        in_valid30 = '0;
        in_data30 = '0;
        out_ready30 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow_err), 0);
        chk("rst_skew", 32'(skew_err), 0);
        chk("rst30_out_valid", 32'(out_valid30), 0);

        // Test 1: basic stream, busy exactly 4 cycles
        drive_set(16'h0001, 1'b1);
        tick();
        in_valid = '0;
        chk("t1_first_data", 32'(out_data), 32'h0001);
        for (int i = 0; i < 4; i++) begin
            chk("t1_busy", 32'(busy), 1);
            chk("t1_valid", 32'(out_valid), 1);
            tick();
        end
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_valid_end", 32'(out_valid), 0);
        chk("t1_data_end", 32'(out_data), 0);
        chk("t1_drained", 32'(q4.size()), 0);
        chk("t1_overflow", 32'(overflow_err), 0);
        chk("t1_skew", 32'(skew_err), 0);

        // Test 2: backpressure on 2nd and 3rd stream cycles
        drive_set(16'h0001, 1'b1);
        tick();
        in_valid = '0;
        tick();
        out_ready = 1'b0;
        chk("t2_hold_a_data", 32'(out_data), 32'h0002);
        chk("t2_hold_a_valid", 32'(out_valid), 1);
        tick();
        chk("t2_hold_b_data", 32'(out_data), 32'h0002);
        chk("t2_hold_b_valid", 32'(out_valid), 1);
        tick();
        chk("t2_hold_c_data", 32'(out_data), 32'h0002);
        out_ready = 1'b1;
        wait_idle("t2_idle");
        chk("t2_drained", 32'(q4.size()), 0);

        // Test 3: back-to-back capture on the final transfer
        drive_set(16'h0001, 1'b1);
        tick();
        in_valid = '0;
        tick();
        tick();
        tick();
        chk("t3_pre_last", 32'(out_last), 1);
        drive_set(16'h0005, 1'b1);
        tick();
        in_valid = '0;
        chk("t3_no_gap_valid", 32'(out_valid), 1);
        chk("t3_no_gap_data", 32'(out_data), 32'h0005);
        wait_idle("t3_idle");
        chk("t3_drained", 32'(q4.size()), 0);
        chk("t3_overflow", 32'(overflow_err), 0);

        // Test 4: capture while streaming is dropped and flagged
        drive_set(16'h0001, 1'b1);
        tick();
        in_valid = '0;
        tick();
        drive_set(16'h0009, 1'b0);
        tick();
        in_valid = '0;
        chk("t4_overflow", 32'(overflow_err), 1);
        chk("t4_stream_data", 32'(out_data), 32'h0003);
        wait_idle("t4_idle");
        chk("t4_drained", 32'(q4.size()), 0);
        chk("t4_valid_end", 32'(out_valid), 0);
        tick();
        chk("t4_overflow_sticky", 32'(overflow_err), 1);

        // Test 5: partial strobe
        in_valid = 4'b0111;
        tick();
        in_valid = '0;
        chk("t5_no_capture", 32'(out_valid), 0);
        chk("t5_skew", 32'(skew_err), 1);
        tick();
        tick();
        chk("t5_skew_sticky", 32'(skew_err), 1);
        chk("t5_still_idle", 32'(busy), 0);

        // Test 6: rst mid-stream, capture in rst cycle ignored
        drive_set(16'h0001, 1'b1);
        tick();
        in_valid = '0;
        tick();
        tick();
        chk("t6_pre_rst_data", 32'(out_data), 32'h0003);
        rst = 1'b1;
        drive_set(16'h0020, 1'b0);
        tick();
        rst = 1'b0;
        in_valid = '0;
        q4.delete();
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_data", 32'(out_data), 0);
        chk("t6_overflow", 32'(overflow_err), 0);
        chk("t6_skew", 32'(skew_err), 0);
        tick();
        chk("t6_rst_capture_ignored", 32'(out_valid), 0);
        drive_set(16'h00A0, 1'b1);
        tick();
        in_valid = '0;
        chk("t6_fresh_first", 32'(out_data), 32'h00A0);
        wait_idle("t6_idle");
        chk("t6_drained", 32'(q4.size()), 0);

        // Test 1 rerun with 30 neurons
        in_valid30 = '1;
        for (int i = 0; i < 30; i++) begin
            in_data30[i*16 +: 16] = 16'h0100 + 16'(i);
            q30.push_back({(i == 29), 16'h0100 + 16'(i)});
        end
        tick();
        in_valid30 = '0;
        chk("n30_first", 32'(out_data30), 32'h0100);
        for (int i = 0; i < 30; i++) begin
            chk("n30_busy", 32'(busy30), 1);
            tick();
        end
        chk("n30_busy_end", 32'(busy30), 0);
        chk("n30_valid_end", 32'(out_valid30), 0);
        chk("n30_drained", 32'(q30.size()), 0);
        chk("n30_overflow", 32'(overflow_err30), 0);
        chk("n30_skew", 32'(skew_err30), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
